// File: rtl/mips_mc_pkg.sv
// Shared types and constants for the multicycle MIPS controller: state
// encoding, opcodes, alu_op encoding and the control word carried to the datapath.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // fetch_gate marks strobes that only fire once memory reports ready
  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       fetch_gate;
    logic       branch;
    logic       i_or_d;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
  } ctrl_word_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Pure state-to-control-word decode; encodings 12-15 fall back to FETCH values.
module mc_ctrl_outdec
  import mips_mc_pkg::*;
(
  input  state_t     state_i,
  output ctrl_word_t cw_o
);

  always_comb begin
    cw_o = '0;
    case (state_i)
      S_DECODE: cw_o.alu_src_b = 2'b11;
      S_MEMADR: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_src_b = 2'b10;
      end
      S_MEMRD:  cw_o.i_or_d = 1'b1;
      S_MEMWB: begin
        cw_o.mem_to_reg = 1'b1;
        cw_o.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        cw_o.i_or_d    = 1'b1;
        cw_o.mem_write = 1'b1;
      end
      S_EXEC: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        cw_o.reg_dst   = 1'b1;
        cw_o.reg_write = 1'b1;
      end
      S_BRANCH: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_op    = ALUOP_SUB;
        cw_o.pc_src    = 2'b01;
        cw_o.branch    = 1'b1;
      end
      S_ADDIEX: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_src_b = 2'b10;
      end
      S_ADDIWB: cw_o.reg_write = 1'b1;
      S_JUMP: begin
        cw_o.pc_src   = 2'b10;
        cw_o.pc_write = 1'b1;
      end
      default: begin
        cw_o.ir_write   = 1'b1;
        cw_o.pc_write   = 1'b1;
        cw_o.fetch_gate = 1'b1;
        cw_o.alu_src_b  = 2'b01;
        cw_o.alu_op     = ALUOP_ADD;
      end
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main controller: state register, opcode-driven next state,
// and ready/zero/reset gating of the decoded control word.
module mc_main_ctrl
  import mips_mc_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    op_i6,
  input  logic               zero_i,
  input  logic               mem_ready_i,
  output logic               ir_write_o,
  output logic               pc_en_o,
  output logic               i_or_d_o,
  output logic               mem_write_o,
  output logic               reg_write_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o2,
  output logic [1:0]         pc_src_o2,
  output logic [ALUOP_W-1:0] alu_op_o2,
  output logic               illegal_o,
  output logic [3:0]         state_o4
);

  state_t     state_q, state_d, dec_state;
  ctrl_word_t cw;
  logic       ready_ok;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_i6)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op_i6 == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready_i ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready_i ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // While in reset the outputs present FETCH, not the abandoned state
  assign dec_state = rst_i ? S_FETCH : state_q;

  mc_ctrl_outdec u_outdec (
    .state_i (dec_state),
    .cw_o    (cw)
  );

  assign ready_ok     = ~cw.fetch_gate | mem_ready_i;
  assign ir_write_o   = ~rst_i & cw.ir_write & ready_ok;
  assign pc_en_o      = ~rst_i & ((cw.pc_write & ready_ok) | (cw.branch & zero_i));
  assign mem_write_o  = ~rst_i & cw.mem_write;
  assign reg_write_o  = ~rst_i & cw.reg_write;
  assign illegal_o    = ~rst_i & (state_q == S_DECODE) & ~op_legal(op_i6);
  assign i_or_d_o     = cw.i_or_d;
  assign reg_dst_o    = cw.reg_dst;
  assign mem_to_reg_o = cw.mem_to_reg;
  assign alu_src_a_o  = cw.alu_src_a;
  assign alu_src_b_o2 = cw.alu_src_b;
  assign pc_src_o2    = cw.pc_src;
  assign alu_op_o2    = cw.alu_op;
  assign state_o4     = dec_state;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Bench for mc_main_ctrl: an instruction-level reference model (per-opcode
// state lists, per-state output table) checked every cycle, plus directed scenarios.
module tb_mc_main_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [5:0] op_i6 = 6'd0;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       ir_write_o, pc_en_o, i_or_d_o, mem_write_o, reg_write_o;
  logic       reg_dst_o, mem_to_reg_o, alu_src_a_o, illegal_o;
  logic [1:0] alu_src_b_o2, pc_src_o2, alu_op_o2;
  logic [3:0] state_o4;

  int vectors = 0;
  int miscompares = 0;

  typedef int q_t[$];
  q_t plan;

  mc_main_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .op_i6(op_i6), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .ir_write_o(ir_write_o), .pc_en_o(pc_en_o),
    .i_or_d_o(i_or_d_o), .mem_write_o(mem_write_o), .reg_write_o(reg_write_o),
    .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o2(alu_src_b_o2), .pc_src_o2(pc_src_o2), .alu_op_o2(alu_op_o2),
    .illegal_o(illegal_o), .state_o4(state_o4)
  );

  always #5 clk_i = ~clk_i;

  // Whole instruction as a list of states, FETCH first
  function automatic q_t seq_of(input logic [5:0] op);
    q_t q;
    case (op)
      6'b000000: q = '{0, 1, 6, 7};
      6'b100011: q = '{0, 1, 2, 3, 4};
      6'b101011: q = '{0, 1, 2, 5};
      6'b000100: q = '{0, 1, 8};
      6'b001000: q = '{0, 1, 9, 10};
      6'b000010: q = '{0, 1, 11};
      default:   q = '{0, 1};
    endcase
    return q;
  endfunction

  function automatic int cur_st();
    return (plan.size() != 0) ? plan[0] : 0;
  endfunction

  function automatic logic [18:0] dut_vec();
    return {state_o4, ir_write_o, pc_en_o, i_or_d_o, mem_write_o, reg_write_o,
            reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o2, pc_src_o2,
            alu_op_o2, illegal_o};
  endfunction

  function automatic logic [18:0] model_vec();
    int st;
    logic ir, pc, iord, mw, rw, rd, m2r, asa, ill;
    logic [1:0] asb, pcs, aop;
    st = rst_i ? 0 : cur_st();
    {ir, pc, iord, mw, rw, rd, m2r, asa, ill} = '0;
    {asb, pcs, aop} = '0;
    case (st)
      0:  begin asb = 2'b01; ir = mem_ready_i; pc = mem_ready_i; end
      1:  begin
            asb = 2'b11;
            ill = !(op_i6 inside {6'b000000, 6'b100011, 6'b101011,
                                  6'b000100, 6'b001000, 6'b000010});
          end
      2:  begin asa = 1; asb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; pc = zero_i; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin pcs = 2'b10; pc = 1; end
      default: ;
    endcase
    if (rst_i) {ir, pc, mw, rw, ill} = '0;
    return {st[3:0], ir, pc, iord, mw, rw, rd, m2r, asa, asb, pcs, aop, ill};
  endfunction

  // Advance the model across the coming clock edge using the applied inputs
  task automatic advance();
    int s;
    if (rst_i) begin
      plan.delete();
    end else begin
      if (plan.size() == 0) plan = seq_of(op_i6);
      s = plan[0];
      if (!((s == 0 || s == 3 || s == 5) && !mem_ready_i)) void'(plan.pop_front());
    end
  endtask

  task automatic apply(input bit r, input bit rdy, input bit z, input logic [5:0] op);
    @(negedge clk_i);
    rst_i = r; mem_ready_i = rdy; zero_i = z; op_i6 = op;
    #1;
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 6'd0); advance();
    apply(1, 1, 1, 6'd0); advance();
  endtask

  task automatic test_reset();
    logic [18:0] e;
    apply(1, 1, 1, 6'b000010);
    e = model_vec(); vectors++;
    if (dut_vec() !== e) begin miscompares++;
      $display("FAIL reset_ready1: got %h want %h", dut_vec(), e); end
    advance();
    apply(1, 0, 0, 6'b111111);
    e = model_vec(); vectors++;
    if (dut_vec() !== e) begin miscompares++;
      $display("FAIL reset_ready0: got %h want %h", dut_vec(), e); end
    advance();
  endtask

  task automatic test_rtype();
    int st[5] = '{0, 1, 6, 7, 0};
    logic [18:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, 0, 6'b000000);
      e = model_vec(); vectors++;
      if (dut_vec() !== e || state_o4 !== st[i][3:0]) begin miscompares++;
        $display("FAIL rtype cyc%0d: got %h want %h", i, dut_vec(), e); end
      advance();
    end
  endtask

  task automatic test_lw_wait();
    bit rdy[8] = '{1, 1, 1, 0, 0, 1, 1, 1};
    int st[8]  = '{0, 1, 2, 3, 3, 3, 4, 0};
    logic [18:0] e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(0, rdy[i], 0, 6'b100011);
      e = model_vec(); vectors++;
      if (dut_vec() !== e || state_o4 !== st[i][3:0]) begin miscompares++;
        $display("FAIL lw_wait cyc%0d: got %h want %h", i, dut_vec(), e); end
      advance();
    end
  endtask

  task automatic test_beq();
    logic [18:0] e;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      for (int i = 0; i < 4; i++) begin
        apply(0, 1, (t == 0), 6'b000100);
        e = model_vec(); vectors++;
        if (dut_vec() !== e) begin miscompares++;
          $display("FAIL beq_z%0d cyc%0d: got %h want %h", (t == 0), i, dut_vec(), e); end
        if (i == 2) begin
          vectors++;
          if (pc_en_o !== (t == 0) || pc_src_o2 !== 2'b01 || alu_op_o2 !== 2'b01) begin
            miscompares++;
            $display("FAIL beq_branch: got pc_en=%b pc_src=%b alu_op=%b want pc_en=%b 01 01",
                     pc_en_o, pc_src_o2, alu_op_o2, (t == 0));
          end
        end
        advance();
      end
    end
  endtask

  task automatic test_fetch_stall();
    bit rdy[7] = '{0, 0, 0, 1, 1, 1, 1};
    int st[7]  = '{0, 0, 0, 0, 1, 6, 7};
    logic [18:0] e;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(0, rdy[i], 0, 6'b000000);
      e = model_vec(); vectors++;
      if (dut_vec() !== e || state_o4 !== st[i][3:0]) begin miscompares++;
        $display("FAIL fetch_stall cyc%0d: got %h want %h", i, dut_vec(), e); end
      advance();
    end
  endtask

  task automatic test_illegal();
    int st[4] = '{0, 1, 0, 1};
    logic [18:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, 0, 6'b111111);
      e = model_vec(); vectors++;
      if (dut_vec() !== e || state_o4 !== st[i][3:0] || illegal_o !== (st[i] == 1)) begin
        miscompares++;
        $display("FAIL illegal cyc%0d: got %h want %h", i, dut_vec(), e); end
      advance();
    end
  endtask

  task automatic test_reset_mid_sw();
    bit r[6]   = '{0, 0, 0, 0, 1, 0};
    bit rdy[6] = '{1, 1, 1, 0, 0, 0};
    int st[6]  = '{0, 1, 2, 5, 0, 0};
    logic [18:0] e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply(r[i], rdy[i], 0, 6'b101011);
      e = model_vec(); vectors++;
      if (dut_vec() !== e || state_o4 !== st[i][3:0] || mem_write_o !== (i == 3)) begin
        miscompares++;
        $display("FAIL reset_mid_sw cyc%0d: got %h want %h", i, dut_vec(), e); end
      advance();
    end
  endtask

  task automatic test_latency();
    logic [5:0] ops[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    int lat_exp[6]     = '{4, 5, 4, 3, 4, 3};
    int lat;
    for (int k = 0; k < 6; k++) begin
      do_reset();
      lat = -1;
      for (int n = 0; n < 16 && lat < 0; n++) begin
        apply(0, 1, 0, ops[k]);
        if (n > 0 && state_o4 === 4'd0) lat = n;
        advance();
      end
      vectors++;
      if (lat != lat_exp[k]) begin miscompares++;
        $display("FAIL latency op=%b: got %0d want %0d", ops[k], lat, lat_exp[k]); end
    end
  endtask

  task automatic test_random();
    logic [5:0] pool[8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                            6'b001000, 6'b000010, 6'b001100, 6'b111111};
    logic [5:0] op;
    logic [18:0] e;
    bit r;
    do_reset();
    op = 6'd0;
    for (int i = 0; i < 400; i++) begin
      if (plan.size() == 0) op = pool[$urandom_range(0, 7)];
      r = ($urandom_range(0, 99) < 3);
      apply(r, ($urandom_range(0, 99) < 70), 1'($urandom_range(0, 1)), op);
      e = model_vec(); vectors++;
      if (dut_vec() !== e) begin miscompares++;
        $display("FAIL random cyc%0d op=%b: got %h want %h", i, op, dut_vec(), e); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_fetch_stall();
    test_illegal();
    test_reset_mid_sw();
    test_latency();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
